onchip_mem_block_copier: RTL and testbench
==========================================

Name: onchip_mem_block_copier

Overview:
- Avalon-MM master DMA engine that copies a block of 32-bit words between two on-chip memory slaves (a single-port altsyncram with 13-bit word address, 4-bit byteenable and 1-cycle read latency).
- The read master drives the source memory; the write master drives the destination memory.
- A processor core programs the block through a 4-register CSR slave and is notified by a level interrupt.
- Used for inter-core buffer transfers in the multicore platform.

Parameters:
- ADDR_W, 13, word address width of both master ports (memory depth 8192).
- DATA_W, 32, data width of both master ports.
- LEN_W, 14, width of the length register; covers 0..8192 words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- csr_address  in  2  CSR word select.
- csr_chipselect  in  1  CSR select.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, valid cycle after csr_read.
- irq  out  1  level interrupt = done & irq_en.
- rd_address  out  ADDR_W  source word address.
- rd_chipselect  out  1  source read request.
- rd_byteenable  out  4  always 4'hF.
- rd_readdata  in  DATA_W  source data, valid 1 cycle after request.
- wr_address  out  ADDR_W  destination word address.
- wr_chipselect  out  1  destination select.
- wr_write  out  1  destination write strobe.
- wr_byteenable  out  4  4'hF during writes, else 0.
- wr_writedata  out  DATA_W  destination data.

Behaviour:

Reset:
- Every output and register goes to 0.
- FSM enters IDLE.
- Any in-flight transfer is abandoned with no further master activity.

CSR map (a CSR write requires chipselect & write):
- 0 SRC [ADDR_W-1:0].
- 1 DST [ADDR_W-1:0].
- 2 LEN [LEN_W-1:0].
- 3 CTRL.
  - Write: bit0 GO, bit1 IRQ_EN (stored), bit2 DONE_CLR.
  - Read: {29'b0, irq_en, done, busy}.
- Unused bits read 0.
- csr_readdata is registered: 1-cycle latency, holds its value otherwise.
- Writes to SRC/DST/LEN while busy are ignored. IRQ_EN is always writable.

FSM states: IDLE, RUN, DRAIN.
- IDLE: GO write in cycle c loads the count and clears done.
  - LEN=0: done set at c+1, no master activity, stays IDLE.
  - LEN>0: busy=1 from c+1, enters RUN.
- RUN:
  - One read per cycle: rd_chipselect=1, rd_address = SRC+i, for i=0..LEN-1, in cycles c+1..c+LEN.
  - After the last read, enters DRAIN.
- Data pipeline:
  - rd_readdata is sampled into a data register at (read cycle)+1.
  - The write issues at (read cycle)+2: wr_chipselect=wr_write=1, wr_address = DST+i, wr_writedata = sampled word.
  - Fixed read-to-write latency is 2 cycles.
  - Writes occur in cycles c+3..c+LEN+2.
- DRAIN:
  - Waits until the last write has issued.
  - At c+LEN+3: busy=0, done=1, returns to IDLE.
- Master outputs return to 0 in every cycle without a request.

Boundary rules:
- Address arithmetic is modulo 2^ADDR_W; SRC+i and DST+i wrap past 8191 to 0.
- LEN > 8192 is truncated to LEN_W bits as written; the count is exact.
- GO while busy is ignored; the transfer continues unchanged.
- done set and DONE_CLR in the same cycle: set wins.
- GO with DONE_CLR: done cleared, transfer starts.
- Overlapping source/destination in the same physical memory is not supported; the result is undefined.
- irq updates combinationally from the registered done and irq_en bits.

Test Plan:
- SRC=0x010, DST=0x100, LEN=4, source words 0xA0..0xA3:
  - GO at cycle c -> reads at c+1..c+4.
  - Writes of 0xA0..0xA3 to 0x100..0x103 at c+3..c+6.
  - done=1 and busy=0 at c+7.
  - CTRL read returns 0x2.
- LEN=0, GO -> no rd_/wr_ strobes; done=1 the next cycle.
- Wrap: SRC=0x1FFE, DST=0x1FFF, LEN=3 -> read addresses 0x1FFE, 0x1FFF, 0x0000; write addresses 0x1FFF, 0x0000, 0x0001.
- IRQ_EN=1, LEN=2 transfer:
  - irq rises with done.
  - CTRL write of 0x4 (DONE_CLR) -> irq=0 next cycle.
  - IRQ_EN=0 with done=1 -> irq=0.
- During LEN=8 run:
  - Write SRC=0x55 and re-issue GO mid-transfer -> both ignored; all 8 words copied from the original SRC.
  - Then reset_n low mid-transfer -> all strobes 0 immediately; state IDLE with busy=0, done=0.
- Full-depth copy, LEN=8192, SRC=DST=0 into a separate memory -> 8192 writes with matching data; done at c+8195.

Source files
------------

// File: rtl/onchip_mem_block_copier.sv
// Avalon-MM DMA that copies LEN words SRC->DST, one read per cycle with a fixed 2-cycle read-to-write latency.
// No backpressure: both slaves are zero-wait on-chip RAMs, so the engine never stalls once started.
module onchip_mem_block_copier #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_chipselect,
  output logic [3:0]        rd_byteenable,
  input  logic [DATA_W-1:0] rd_readdata,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_chipselect,
  output logic              wr_write,
  output logic [3:0]        wr_byteenable,
  output logic [DATA_W-1:0] wr_writedata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_t            state;
  logic [ADDR_W-1:0] src, dst, rd_ptr, wr_ptr;
  logic [LEN_W-1:0]  len, rd_rem;
  logic              irq_en, done, rd_pend;
  logic              busy, csr_wr, go, done_clr;
  logic              csr_unused;

  assign busy          = (state != IDLE);
  assign csr_wr        = csr_chipselect & csr_write;
  assign go            = csr_wr && (csr_address == 2'd3) && csr_writedata[0];
  assign done_clr      = csr_wr && (csr_address == 2'd3) && csr_writedata[2];
  assign irq           = done & irq_en;
  assign rd_byteenable = 4'hF;
  assign csr_unused    = ^csr_writedata[31:LEN_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      len           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rd_rem        <= '0;
      irq_en        <= 1'b0;
      done          <= 1'b0;
      rd_pend       <= 1'b0;
      csr_readdata  <= '0;
      rd_address    <= '0;
      rd_chipselect <= 1'b0;
      wr_address    <= '0;
      wr_chipselect <= 1'b0;
      wr_write      <= 1'b0;
      wr_byteenable <= 4'h0;
      wr_writedata  <= '0;
    end else begin
      if (csr_chipselect && csr_read) begin
        case (csr_address)
          2'd0: csr_readdata <= 32'(src);
          2'd1: csr_readdata <= 32'(dst);
          2'd2: csr_readdata <= 32'(len);
          2'd3: csr_readdata <= {29'b0, irq_en, done, busy};
        endcase
      end

      if (csr_wr && !busy) begin
        case (csr_address)
          2'd0: src <= csr_writedata[ADDR_W-1:0];
          2'd1: dst <= csr_writedata[ADDR_W-1:0];
          2'd2: len <= csr_writedata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (csr_wr && csr_address == 2'd3) irq_en <= csr_writedata[1];
      // Clear first so a same-cycle completion below overrides it.
      if (done_clr) done <= 1'b0;

      rd_chipselect <= 1'b0;
      rd_address    <= '0;
      wr_chipselect <= 1'b0;
      wr_write      <= 1'b0;
      wr_byteenable <= 4'h0;
      wr_address    <= '0;
      wr_writedata  <= '0;

      // rd_pend marks the cycle the RAM presents data; capture it straight into the write port.
      rd_pend <= rd_chipselect;
      if (rd_pend) begin
        wr_chipselect <= 1'b1;
        wr_write      <= 1'b1;
        wr_byteenable <= 4'hF;
        wr_address    <= wr_ptr;
        wr_writedata  <= rd_readdata;
        wr_ptr        <= wr_ptr + ADDR_ONE;
      end

      case (state)
        IDLE: begin
          if (go) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              done          <= 1'b0;
              state         <= RUN;
              rd_chipselect <= 1'b1;
              rd_address    <= src;
              rd_ptr        <= src + ADDR_ONE;
              rd_rem        <= len - LEN_ONE;
              wr_ptr        <= dst;
            end
          end
        end
        RUN: begin
          if (rd_rem == '0) begin
            state <= DRAIN;
          end else begin
            rd_chipselect <= 1'b1;
            rd_address    <= rd_ptr;
            rd_ptr        <= rd_ptr + ADDR_ONE;
            rd_rem        <= rd_rem - LEN_ONE;
          end
        end
        DRAIN: begin
          // Last write is on the bus when no read data is still pending.
          if (wr_chipselect && !rd_pend) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_block_copier.sv
// Directed bench for onchip_mem_block_copier: table of block copies plus hand sequences for irq, done races and reset.
module tb_onchip_mem_block_copier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_address;
  logic        csr_chipselect, csr_write, csr_read;
  logic [31:0] csr_writedata, csr_readdata;
  logic        irq;
  logic [12:0] rd_address, wr_address;
  logic        rd_chipselect, wr_chipselect, wr_write;
  logic [3:0]  rd_byteenable, wr_byteenable;
  logic [31:0] rd_readdata, wr_writedata;

  onchip_mem_block_copier #(.ADDR_W(13), .DATA_W(32), .LEN_W(14)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_chipselect(csr_chipselect), .csr_write(csr_write),
    .csr_read(csr_read), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .irq(irq),
    .rd_address(rd_address), .rd_chipselect(rd_chipselect), .rd_byteenable(rd_byteenable),
    .rd_readdata(rd_readdata),
    .wr_address(wr_address), .wr_chipselect(wr_chipselect), .wr_write(wr_write),
    .wr_byteenable(wr_byteenable), .wr_writedata(wr_writedata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM with 1-cycle read latency.
  logic [31:0] src_mem [0:8191];
  always @(posedge clk) if (rd_chipselect) rd_readdata <= src_mem[rd_address];

  int          rd_cyc_q[$];
  logic [12:0] rd_addr_q[$];
  int          wr_cyc_q[$];
  logic [12:0] wr_addr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [3:0]  wr_be_q[$];

  always @(negedge clk) begin
    if (rd_chipselect) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(rd_address);
    end
    if (wr_chipselect && wr_write) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(wr_address);
      wr_dat_q.push_back(wr_writedata);
      wr_be_q.push_back(wr_byteenable);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_cyc_q.delete(); rd_addr_q.delete();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_dat_q.delete(); wr_be_q.delete();
  endtask

  // Called on a negedge; occupies exactly one cycle and returns on the next negedge.
  task automatic csr_op(input logic wr, input logic rd, input logic [1:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
    csr_chipselect = 1'b1; csr_write = wr; csr_read = rd;
    csr_address = addr; csr_writedata = wdata;
    @(negedge clk);
    csr_chipselect = 1'b0; csr_write = 1'b0; csr_read = 1'b0; csr_writedata = '0;
    rdata = csr_readdata;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  typedef struct {
    logic [12:0] src;
    logic [12:0] dst;
    logic [31:0] len_wr;
    logic [31:0] ctrl;
    logic [31:0] base;
    int          n;
    logic [12:0] rd_first, rd_last, wr_first, wr_last;
    int          done_off;
    logic [31:0] exp_ctrl;
    logic        exp_irq;
    logic        inject;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int vi, input vec_t v);
    int c;
    logic [31:0] d0, d1, dummy;
    logic irq_pre, irq_post;
    for (int j = 0; j < v.n; j++) src_mem[13'(32'(v.src) + j)] = v.base + j;
    if (v.inject) for (int j = 0; j < 8; j++) src_mem[13'(32'h55 + j)] = 32'hDEAD0000 + j;
    csr_op(1'b1, 1'b0, 2'd0, 32'(v.src), dummy);
    csr_op(1'b1, 1'b0, 2'd1, 32'(v.dst), dummy);
    csr_op(1'b1, 1'b0, 2'd2, v.len_wr, dummy);
    csr_op(1'b1, 1'b0, 2'd3, 32'h4, dummy);
    clear_logs();
    c = cyc;
    if (v.done_off == 1) begin
      irq_pre = irq;
      csr_op(1'b1, 1'b1, 2'd3, v.ctrl, d0);
    end else begin
      csr_op(1'b1, 1'b0, 2'd3, v.ctrl, dummy);
      if (v.inject) begin
        wait_to(c + 3);
        csr_op(1'b1, 1'b0, 2'd0, 32'h55, dummy);
        csr_op(1'b1, 1'b0, 2'd3, 32'h1, dummy);
      end
      wait_to(c + v.done_off - 1);
      irq_pre = irq;
      csr_op(1'b0, 1'b1, 2'd3, 32'h0, d0);
    end
    irq_post = irq;
    csr_op(1'b0, 1'b1, 2'd3, 32'h0, d1);
    wait_to(c + v.n + 5);

    chk($sformatf("v%0d_irq_before_done", vi), 32'(irq_pre), 32'h0);
    chk($sformatf("v%0d_stat_before_done", vi), 32'(d0[1:0]), (v.n > 0) ? 32'h1 : 32'h0);
    chk($sformatf("v%0d_stat_done", vi), d1, v.exp_ctrl);
    chk($sformatf("v%0d_irq_done", vi), 32'(irq_post), 32'(v.exp_irq));
    chk($sformatf("v%0d_num_reads", vi), rd_cyc_q.size(), v.n);
    chk($sformatf("v%0d_num_writes", vi), wr_cyc_q.size(), v.n);
    for (int j = 0; j < v.n && j < rd_cyc_q.size(); j++) begin
      chk($sformatf("v%0d_rd_cycle%0d", vi, j), rd_cyc_q[j], c + 1 + j);
      chk($sformatf("v%0d_rd_addr%0d", vi, j), 32'(rd_addr_q[j]), 32'(13'(32'(v.src) + j)));
    end
    for (int j = 0; j < v.n && j < wr_cyc_q.size(); j++) begin
      chk($sformatf("v%0d_wr_cycle%0d", vi, j), wr_cyc_q[j], c + 3 + j);
      chk($sformatf("v%0d_wr_addr%0d", vi, j), 32'(wr_addr_q[j]), 32'(13'(32'(v.dst) + j)));
      chk($sformatf("v%0d_wr_data%0d", vi, j), wr_dat_q[j], v.base + j);
      chk($sformatf("v%0d_wr_be%0d", vi, j), 32'(wr_be_q[j]), 32'hF);
    end
    if (v.n > 0 && rd_addr_q.size() == v.n && wr_addr_q.size() == v.n) begin
      chk($sformatf("v%0d_rd_first", vi), 32'(rd_addr_q[0]), 32'(v.rd_first));
      chk($sformatf("v%0d_rd_last", vi), 32'(rd_addr_q[v.n-1]), 32'(v.rd_last));
      chk($sformatf("v%0d_wr_first", vi), 32'(wr_addr_q[0]), 32'(v.wr_first));
      chk($sformatf("v%0d_wr_last", vi), 32'(wr_addr_q[v.n-1]), 32'(v.wr_last));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [31:0] d;

    //          src      dst      len_wr      ctrl   base          n     rd_first rd_last  wr_first wr_last  off   ctrl  irq  inj
    vecs[0] = '{13'h010, 13'h100, 32'h4,      32'h1, 32'h000000A0, 4,    13'h010, 13'h013, 13'h100, 13'h103, 7,    32'h2, 1'b0, 1'b0};
    vecs[1] = '{13'h005, 13'h006, 32'h0,      32'h1, 32'h0,        0,    13'h000, 13'h000, 13'h000, 13'h000, 1,    32'h2, 1'b0, 1'b0};
    vecs[2] = '{13'h1FFE,13'h1FFF,32'h3,      32'h1, 32'h000000B0, 3,    13'h1FFE,13'h0000,13'h1FFF,13'h0001,6,    32'h2, 1'b0, 1'b0};
    vecs[3] = '{13'h200, 13'h300, 32'h2,      32'h3, 32'h000000D0, 2,    13'h200, 13'h201, 13'h300, 13'h301, 5,    32'h6, 1'b1, 1'b0};
    vecs[4] = '{13'h007, 13'h008, 32'h1,      32'h5, 32'h000000E0, 1,    13'h007, 13'h007, 13'h008, 13'h008, 4,    32'h2, 1'b0, 1'b0};
    vecs[5] = '{13'h040, 13'h050, 32'h4003,   32'h1, 32'h000000F0, 3,    13'h040, 13'h042, 13'h050, 13'h052, 6,    32'h2, 1'b0, 1'b0};
    vecs[6] = '{13'h020, 13'h080, 32'h8,      32'h1, 32'h000000C0, 8,    13'h020, 13'h027, 13'h080, 13'h087, 11,   32'h2, 1'b0, 1'b1};
    vecs[7] = '{13'h000, 13'h000, 32'h2000,   32'h1, 32'h5A000000, 8192, 13'h0000,13'h1FFF,13'h0000,13'h1FFF,8195, 32'h2, 1'b0, 1'b0};

    for (int i = 0; i < 8192; i++) src_mem[i] = 32'h0;
    reset_n = 1'b0;
    csr_chipselect = 1'b0; csr_write = 1'b0; csr_read = 1'b0;
    csr_address = 2'd0; csr_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_port", 32'({rd_chipselect, rd_address}), 32'h0);
    chk("rst_wr_port", 32'({wr_chipselect, wr_write, wr_byteenable, wr_address}), 32'h0);
    chk("rst_wr_data", wr_writedata, 32'h0);
    chk("rst_csr_readdata", csr_readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // irq follows done & irq_en; DONE_CLR and IRQ_EN=0 both drop it.
    csr_op(1'b1, 1'b0, 2'd2, 32'h0, d);
    csr_op(1'b1, 1'b0, 2'd3, 32'h3, d);
    chk("irq_set_len0", 32'(irq), 32'h1);
    csr_op(1'b1, 1'b0, 2'd3, 32'h6, d);
    chk("irq_after_done_clr", 32'(irq), 32'h0);
    csr_op(1'b1, 1'b0, 2'd3, 32'h3, d);
    chk("irq_set_again", 32'(irq), 32'h1);
    csr_op(1'b1, 1'b0, 2'd3, 32'h0, d);
    chk("irq_en_cleared", 32'(irq), 32'h0);
    csr_op(1'b0, 1'b1, 2'd3, 32'h0, d);
    chk("done_kept_irq_off", d, 32'h2);

    // DONE_CLR in the same cycle done is set: set wins.
    csr_op(1'b1, 1'b0, 2'd2, 32'h1, d);
    csr_op(1'b1, 1'b0, 2'd3, 32'h4, d);
    c = cyc;
    csr_op(1'b1, 1'b0, 2'd3, 32'h1, d);
    wait_to(c + 3);
    csr_op(1'b1, 1'b1, 2'd3, 32'h4, d);
    chk("race_stat_busy", d, 32'h1);
    csr_op(1'b0, 1'b1, 2'd3, 32'h0, d);
    chk("race_set_wins", d, 32'h2);

    // Reset in the middle of an 8-word copy.
    csr_op(1'b1, 1'b0, 2'd0, 32'h30, d);
    csr_op(1'b1, 1'b0, 2'd1, 32'h90, d);
    csr_op(1'b1, 1'b0, 2'd2, 32'h8, d);
    csr_op(1'b1, 1'b0, 2'd3, 32'h4, d);
    c = cyc;
    csr_op(1'b1, 1'b0, 2'd3, 32'h3, d);
    wait_to(c + 4);
    chk("mid_rd_active", 32'(rd_chipselect), 32'h1);
    chk("mid_wr_active", 32'(wr_chipselect), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_port", 32'({rd_chipselect, rd_address}), 32'h0);
    chk("mid_rst_wr_port", 32'({wr_chipselect, wr_write, wr_byteenable, wr_address}), 32'h0);
    chk("mid_rst_wr_data", wr_writedata, 32'h0);
    clear_logs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_reads", rd_cyc_q.size(), 0);
    chk("post_rst_no_writes", wr_cyc_q.size(), 0);
    csr_op(1'b0, 1'b1, 2'd3, 32'h0, d);
    chk("post_rst_ctrl", d, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
